uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of byte entries; it SHALL be a power of two, 4..256.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the bits per entry.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 The block SHALL have port we, input, 1, meaning the CPU write request, already qualified by chip select and wstrb[0].
REQ-006 The block SHALL have port din, input, WIDTH, meaning the CPU write data.
REQ-007 The block SHALL have port ready, output, 1, meaning the write is accepted this cycle; combinational, we && !full.
REQ-008 The block SHALL have port full, output, 1, meaning count == DEPTH.
REQ-009 The block SHALL have port empty, output, 1, meaning count == 0.
REQ-010 The block SHALL have port count, output, log2(DEPTH)+1, meaning the number of occupied entries.
REQ-011 The block SHALL have port tx_we, output, 1, meaning the one-cycle load strobe to uart_tx.
REQ-012 The block SHALL have port tx_din, output, WIDTH, meaning the byte to uart_tx; registered and valid while tx_we is high.
REQ-013 The block SHALL have port tx_busy, input, 1, meaning uart_tx is serialising.

Function
REQ-014 The block SHALL push din at the clock edge where we && !full, then advance wr_ptr modulo DEPTH.
REQ-015 The block SHALL ignore a write while full: no storage, no pointer change, and ready low, so the CPU stalls.
REQ-016 The block SHALL run a drain FSM with states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-017 In IDLE, when !empty && !tx_busy, the FSM SHALL pop the head into tx_din, advance rd_ptr modulo DEPTH, and go to ISSUE.
REQ-018 In ISSUE, the FSM SHALL assert tx_we for exactly one cycle, then go to WAIT_BUSY.
REQ-019 In WAIT_BUSY, the FSM SHALL stay until tx_busy = 1, then go to WAIT_DONE.
REQ-020 In WAIT_BUSY, if tx_busy stays low for 4 cycles, the FSM SHALL return to IDLE; this covers a lost handshake.
REQ-021 In WAIT_DONE, the FSM SHALL stay until tx_busy = 0, then go to IDLE.
REQ-022 tx_we SHALL be asserted only in ISSUE, and at most once per popped byte.
REQ-023 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-024 ready SHALL be derived from the registered full, so a same-cycle pop does not admit a push while full.
REQ-025 A push into an empty FIFO SHALL become poppable on the next cycle; there is no fall-through.
REQ-026 Bytes SHALL leave in exact write order across pointer wrap-around.
REQ-027 Minimum latency SHALL be: push at edge N, pop at edge N+1, tx_we high during cycle N+2.

Reset
REQ-028 On rst_n low, asynchronously: wr_ptr = 0, rd_ptr = 0, count = 0, FSM = IDLE, tx_we = 0, tx_din = 0, timeout counter = 0.
REQ-029 Under reset: empty = 1, full = 0, ready = 0.
REQ-030 Reset mid-transfer SHALL discard all stored bytes and any issued byte, with no further tx_we until a new write.
REQ-031 Storage array contents SHALL NOT be reset.
REQ-032 After reset release, the first write SHALL be accepted in the first clk cycle.

Structure
REQ-033 The FSM state encoding and the WAIT_BUSY timeout constant (4) SHALL live in a shared package, uart_pkg.
REQ-034 The storage and pointers SHALL be one sub-module, sync_fifo: WIDTH/DEPTH, push/pop, full/empty/count.
REQ-035 The drain FSM SHALL stay in uart_tx_fifo.
REQ-036 The storage SHALL infer distributed or block RAM with no read-reset.

Verification
REQ-037 Write 0x41, 0x42, 0x43 back-to-back with a uart_tx model (busy 10 cycles, starting 1 cycle after tx_we) -> tx_din shows 0x41, 0x42, 0x43 in order, one tx_we each; empty = 1 at end.
REQ-038 Fill 16 bytes with tx_busy forced high, then write 0x99 -> full = 1, count = 16, ready = 0 while we is held; release busy -> 0x99 accepted once one slot frees.
REQ-039 Write 40 bytes 0x00..0x27 with random we gaps -> output sequence identical; pointers wrap twice.
REQ-040 Hold tx_busy = 0 permanently after tx_we -> FSM returns to IDLE 4 cycles after ISSUE; next byte issued.
REQ-041 Assert rst_n = 0 in WAIT_DONE with count = 5 -> count = 0, tx_we = 0 immediately; no output after release until a new write.
REQ-042 Single write to an empty FIFO at edge N -> tx_we high exactly in cycle N+2 with tx_din = written value.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: drain FSM encoding and
// the handshake timeout used while waiting for the transmitter to go busy.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } drain_state_e;

    localparam int TX_BUSY_TIMEOUT = 4;
    localparam int TMR_W = 3;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TX_BUSY_TIMEOUT - 1);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO storage with wrap-around pointers and occupancy count.
// The storage array is never reset so it maps onto plain RAM.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // power-of-two depth: natural pointer overflow is the modulo
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-side transmit FIFO that drains bytes into a uart_tx one at a time,
// waiting for the transmitter's busy handshake between bytes.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [WIDTH-1:0]         din,
    output logic                     ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     tx_we,
    output logic [WIDTH-1:0]         tx_din,
    input  logic                     tx_busy
);

    drain_state_e state_q, state_d;

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             tx_we_q, tx_we_d;
    logic [WIDTH-1:0] tx_din_q, tx_din_d;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] rd_data;

    // full is a registered count compare, so a same-cycle pop never
    // opens a slot for a push
    assign ready = we && !full && rst_n;
    assign push  = ready;

    assign tx_we  = tx_we_q;
    assign tx_din = tx_din_q;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (din),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        tx_we_d  = 1'b0;
        tx_din_d = tx_din_q;
        pop      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty && !tx_busy) begin
                    pop      = 1'b1;
                    tx_din_d = rd_data;
                    tx_we_d  = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmr_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    tmr_d   = '0;
                    state_d = ST_WAIT_DONE;
                end else if (tmr_q == TMR_LAST) begin
                    // transmitter never acknowledged; give up on this byte
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            tx_we_q  <= 1'b0;
            tx_din_q <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            tx_we_q  <= tx_we_d;
            tx_din_q <= tx_din_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: per-cycle vector table plus sequences
// for full/stall, wrap-around ordering, reset mid-transfer and latency.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0;
    logic [7:0] din = '0;
    logic       ready;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       tx_we;
    logic [7:0] tx_din;
    logic       tx_busy;

    logic       model_en = 1'b0;
    logic       busy_drv = 1'b0;
    int         bcnt;

    int checks = 0;
    int failures = 0;

    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .din     (din),
        .ready   (ready),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .tx_we   (tx_we),
        .tx_din  (tx_din),
        .tx_busy (tx_busy)
    );

    // uart_tx model: busy for 10 cycles starting one cycle after tx_we
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcnt <= 0;
        else if (tx_we) bcnt <= 10;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    assign tx_busy = model_en ? (bcnt != 0) : busy_drv;

    always @(negedge clk) begin
        if (rst_n && tx_we) tx_q.push_back(tx_din);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        we = 1'b0;
        model_en = 1'b0;
        busy_drv = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tx_q.delete();
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic push_byte(input logic [7:0] d);
        int n;
        n = 0;
        we = 1'b1;
        din = d;
        #1;
        while (!ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("push_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget);
        int c;
        c = 0;
        while (tx_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("out_count", tx_q.size(), n);
    endtask

    typedef struct {
        logic       we;
        logic [7:0] din;
        logic       busy;
        logic       rdy;
        logic [4:0] cnt;
        logic       emp;
        logic       ful;
        logic       twe;
        logic [7:0] tdin;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 8'h42, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 8'h41};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h41};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h41};
        vecs[4]  = '{1'b1, 8'h43, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 8'h41};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h41};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h42};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h42};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h42};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h42};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h42};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h42};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h43};

        // reset state, with a write request held during reset
        rst_n = 1'b0;
        we = 1'b1;
        #12;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_tx_we", {31'd0, tx_we}, 32'd0);
        chk("rst_tx_din", {24'd0, tx_din}, 32'd0);
        do_reset();

        // per-cycle vector table: handshake, WAIT_DONE and busy timeout
        for (int i = 0; i < 13; i++) begin
            we = vecs[i].we;
            din = vecs[i].din;
            busy_drv = vecs[i].busy;
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, ready}, {31'd0, vecs[i].rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", i), {27'd0, count}, {27'd0, vecs[i].cnt});
            chk($sformatf("v%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].emp});
            chk($sformatf("v%0d_full", i), {31'd0, full}, {31'd0, vecs[i].ful});
            chk($sformatf("v%0d_tx_we", i), {31'd0, tx_we}, {31'd0, vecs[i].twe});
            chk($sformatf("v%0d_tx_din", i), {24'd0, tx_din}, {24'd0, vecs[i].tdin});
            @(negedge clk);
        end

        // three back-to-back writes against the uart_tx model
        do_reset();
        model_en = 1'b1;
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        wait_out(3, 120);
        repeat (20) @(negedge clk);
        chk("abc_n", tx_q.size(), 3);
        for (int i = 0; i < 3 && i < tx_q.size(); i++)
            chk($sformatf("abc_%0d", i), {24'd0, tx_q[i]}, 32'h41 + i);
        chk("abc_empty", {31'd0, empty}, 32'd1);

        // fill while busy, then stall a write until a slot frees
        do_reset();
        busy_drv = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
        we = 1'b1;
        din = 8'h99;
        #1;
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_count", {27'd0, count}, 32'd16);
        chk("full_ready", {31'd0, ready}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("full_hold_count", {27'd0, count}, 32'd16);
        chk("full_hold_ready", {31'd0, ready}, 32'd0);
        chk("full_hold_none", tx_q.size(), 0);
        model_en = 1'b1;
        push_byte(8'h99);
        wait_out(17, 400);
        repeat (30) @(negedge clk);
        chk("full_n", tx_q.size(), 17);
        for (int i = 0; i < 17 && i < tx_q.size(); i++)
            chk($sformatf("full_ord_%0d", i), {24'd0, tx_q[i]},
                (i < 16) ? 32'h80 + i : 32'h99);

        // 40 bytes with random gaps: pointers wrap twice
        do_reset();
        model_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_byte(8'(i));
        end
        wait_out(40, 3000);
        for (int i = 0; i < 40 && i < tx_q.size(); i++)
            chk($sformatf("wrap_%0d", i), {24'd0, tx_q[i]}, i);
        repeat (20) @(negedge clk);
        chk("wrap_empty", {31'd0, empty}, 32'd1);

        // reset while in WAIT_DONE holding 5 bytes
        do_reset();
        push_byte(8'h60);
        push_byte(8'h61);
        busy_drv = 1'b1;
        for (int i = 2; i < 6; i++) push_byte(8'h60 + 8'(i));
        chk("wd_count", {27'd0, count}, 32'd5);
        chk("wd_first", {24'd0, (tx_q.size() > 0) ? tx_q[0] : 8'hff}, 32'h60);
        we = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("wd_rst_count", {27'd0, count}, 32'd0);
        chk("wd_rst_tx_we", {31'd0, tx_we}, 32'd0);
        chk("wd_rst_empty", {31'd0, empty}, 32'd1);
        chk("wd_rst_ready", {31'd0, ready}, 32'd0);
        we = 1'b0;
        busy_drv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tx_q.delete();
        repeat (20) @(negedge clk);
        chk("wd_silent", tx_q.size(), 0);

        // first-cycle write after reset, minimum latency to tx_we
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        we = 1'b1;
        din = 8'h5a;
        #1;
        chk("lat_ready", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        we = 1'b0;
        chk("lat_count", {27'd0, count}, 32'd1);
        chk("lat_n0_tx_we", {31'd0, tx_we}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_n1_tx_we", {31'd0, tx_we}, 32'd1);
        chk("lat_n1_tx_din", {24'd0, tx_din}, 32'h5a);
        @(posedge clk);
        #1;
        chk("lat_n2_tx_we", {31'd0, tx_we}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
